// File: rtl/sdram_host_responder_if.sv
// Host port of the SDRAM controller: request/data signals driven by the host
// master and the busy/data/flag responses driven by the responder.
interface sdram_host_responder_if #(
    parameter int AW = 24
);
    logic [AW-1:0] addr;
    logic          read_rq;
    logic          write_rq;
    logic          rfsh_rq;
    logic [15:0]   din;
    logic [15:0]   dout;
    logic          busy;
    logic          rfsh_late;
    logic          collision;

    modport master (
        output addr, read_rq, write_rq, rfsh_rq, din,
        input  dout, busy, rfsh_late, collision
    );

    modport slave (
        input  addr, read_rq, write_rq, rfsh_rq, din,
        output dout, busy, rfsh_late, collision
    );
endinterface

// File: rtl/sdram_host_responder.sv
// Stand-in for an SDRAM controller. Serves host reads and writes from an
// on-chip RAM with programmable busy latencies, and flags protocol misuse:
// colliding requests and overdue refreshes.
module sdram_host_responder #(
    parameter int AW          = 24,
    parameter int MEMAW       = 12,
    parameter int INIT_CYCLES = 16,
    parameter int RD_LAT      = 6,
    parameter int WR_LAT      = 5,
    parameter int RFSH_LAT    = 8,
    parameter int RFSH_MAX    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clken,
    sdram_host_responder_if.slave   host
);
    localparam int WDW = $clog2(RFSH_MAX + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR, S_RF} state_t;

    state_t           state;
    logic [15:0]      cnt;
    logic [WDW-1:0]   wd;
    logic [MEMAW-1:0] a_q;
    logic [15:0]      mem [0:(1<<MEMAW)-1];

    logic [2:0] rqs;
    logic       accept;
    logic       multi;

    assign rqs    = {host.write_rq, host.read_rq, host.rfsh_rq};
    assign accept = clken && (state == S_IDLE) && (rqs != 3'd0);
    // more than one bit set in the request vector
    assign multi  = (rqs & (rqs - 3'd1)) != 3'd0;

    // Write lands on the acceptance edge, so a write is all-or-nothing and any
    // later read already sees the new word. No reset on the array itself.
    always_ff @(posedge clk) begin
        if (accept && host.write_rq)
            mem[host.addr[MEMAW-1:0]] <= host.din;
    end

    // Main FSM: init delay, request acceptance, latency countdown, watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_INIT;
            host.busy      <= 1'b1;
            host.dout      <= 16'h0000;
            host.rfsh_late <= 1'b0;
            host.collision <= 1'b0;
            cnt            <= 16'(INIT_CYCLES - 1);
            wd             <= '0;
            a_q            <= '0;
        end else if (clken) begin
            case (state)
                S_INIT: begin
                    if (cnt == 16'd0) begin
                        state     <= S_IDLE;
                        host.busy <= 1'b0;
                        wd        <= '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        host.busy <= 1'b1;
                        a_q       <= host.addr[MEMAW-1:0];
                        if (multi)
                            host.collision <= 1'b1;
                        if (host.write_rq) begin
                            state <= S_WR;
                            cnt   <= 16'(WR_LAT - 1);
                        end else if (host.read_rq) begin
                            state <= S_RD;
                            cnt   <= 16'(RD_LAT - 1);
                        end else begin
                            state <= S_RF;
                            cnt   <= 16'(RFSH_LAT - 1);
                        end
                    end
                end
                default: begin
                    // RD / WR / RF: busy falls on the LAT-th edge after acceptance
                    if (cnt == 16'd0) begin
                        state     <= S_IDLE;
                        host.busy <= 1'b0;
                        if (state == S_RD)
                            host.dout <= mem[a_q];
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
            endcase

            // Refresh watchdog runs once init is over; only a refresh that
            // actually won arbitration restarts it.
            if (state != S_INIT) begin
                if (accept && rqs == 3'b001) begin
                    wd <= '0;
                end else if (wd != WDW'(RFSH_MAX)) begin
                    wd <= wd + 1'b1;
                    if (wd == WDW'(RFSH_MAX - 1))
                        host.rfsh_late <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_host_responder.sv
// Self-checking bench for sdram_host_responder: directed bring-up scenarios
// plus randomized host traffic scored against a word-level memory model.
module tb_sdram_host_responder;
    localparam int INIT_CYCLES = 16;
    localparam int RD_LAT      = 6;
    localparam int WR_LAT      = 5;
    localparam int RFSH_LAT    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clken;
    bit   ce_rand = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   coll_m = 1'b0;
    logic [15:0] mdl [int];

    sdram_host_responder_if #(.AW(24)) h ();

    sdram_host_responder #(
        .AW(24), .MEMAW(12), .INIT_CYCLES(INIT_CYCLES), .RD_LAT(RD_LAT),
        .WR_LAT(WR_LAT), .RFSH_LAT(RFSH_LAT), .RFSH_MAX(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clken(clken), .host(h.slave)
    );

    always #5 clk = ~clk;

    // clock enable changes only on falling edges
    initial begin
        clken = 1'b1;
        forever begin
            @(negedge clk);
            clken = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Count enabled edges until busy is seen low at a falling edge.
    task automatic wait_idle(output int n);
        bit ce;
        n = 0;
        do begin
            @(posedge clk); ce = clken;
            @(negedge clk); if (ce) n++;
        end while (h.busy && n < 400);
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        {h.write_rq, h.read_rq, h.rfsh_rq} = 3'b000;
        coll_m = 1'b0;
        @(negedge clk);
        chk("rst busy", h.busy, 1);
        chk("rst dout", h.dout, 0);
        chk("rst late", h.rfsh_late, 0);
        chk("rst coll", h.collision, 0);
        rst_n = 1'b1;
        wait_idle(n);
        chk("init lat", n, INIT_CYCLES);
    endtask

    // One host transaction; m = {wr, rd, rf}. Called at a falling edge with busy low.
    task automatic host_op(input logic [2:0] m, input logic [23:0] a,
                           input logic [15:0] d, output logic [15:0] q);
        int n, lat, k;
        k   = int'(a) % 4096;
        lat = m[2] ? WR_LAT : (m[1] ? RD_LAT : RFSH_LAT);
        if (m[2]) mdl[k] = d;
        if ($countones(m) > 1) coll_m = 1'b1;
        h.addr = a; h.din = d;
        {h.write_rq, h.read_rq, h.rfsh_rq} = m;
        n = 0;
        do begin @(negedge clk); n++; end while (!h.busy && n < 200);
        {h.write_rq, h.read_rq, h.rfsh_rq} = 3'b000;
        q = 16'h0;
        if (!h.busy) begin
            chk("accept timeout", 0, 1);
            return;
        end
        wait_idle(n);
        chk("op lat", n, lat);
        q = h.dout;
        if (!m[2] && m[1] && mdl.exists(k)) chk("rdata", h.dout, mdl[k]);
        chk("collision", h.collision, coll_m);
    endtask

    task automatic host_loop();
        logic [15:0] q;
        for (int i = 0; i < 64; i++) begin
            if (i % 32 == 0) host_op(3'b001, 24'h0, 16'h0, q);
            host_op(3'b100, 24'h000100 + 24'(i), 16'h5555, q);
        end
        for (int i = 0; i < 64; i++) begin
            if (i % 32 == 0) host_op(3'b001, 24'h0, 16'h0, q);
            host_op(3'b010, 24'h000100 + 24'(i), 16'h0, q);
            host_op(3'b100, 24'h000100 + 24'(i), q + 16'h5555, q);
        end
        for (int i = 0; i < 64; i++) begin
            if (i % 32 == 0) host_op(3'b001, 24'h0, 16'h0, q);
            host_op(3'b010, 24'h000100 + 24'(i), 16'h0, q);
            chk("loop data", q, 16'hAAAA);
        end
        chk("loop coll", h.collision, 0);
        chk("loop late", h.rfsh_late, 0);
    endtask

    initial begin
        logic [15:0] q;
        int n;
        h.addr = '0; h.din = '0;
        {h.write_rq, h.read_rq, h.rfsh_rq} = 3'b000;

        // bring-up
        do_reset();
        host_op(3'b100, 24'h000005, 16'h5555, q);
        host_op(3'b010, 24'h000005, 16'h0, q);
        chk("rd 5555", q, 16'h5555);
        // aliasing above MEMAW
        host_op(3'b100, 24'h001005, 16'hAAAA, q);
        host_op(3'b010, 24'h000005, 16'h0, q);
        chk("alias", q, 16'hAAAA);
        // collision: write wins
        chk("no coll yet", h.collision, 0);
        host_op(3'b110, 24'h000007, 16'h1234, q);
        chk("coll set", h.collision, 1);
        host_op(3'b010, 24'h000007, 16'h0, q);
        chk("rd 1234", q, 16'h1234);

        // randomized traffic with a 50% clock enable
        ce_rand = 1'b1;
        repeat (150) begin
            host_op(3'($urandom_range(1, 7)), 24'($urandom) & 24'hFFF00F,
                    16'($urandom), q);
        end
        ce_rand = 1'b0;

        // refresh watchdog
        do_reset();
        host_op(3'b100, 24'h000009, 16'hBEEF, q);
        host_op(3'b010, 24'h000009, 16'h0, q);
        chk("rd beef", q, 16'hBEEF);
        repeat (990) @(negedge clk);
        chk("late early", h.rfsh_late, 0);
        repeat (40) @(negedge clk);
        chk("late set", h.rfsh_late, 1);
        host_op(3'b001, 24'h0, 16'h0, q);
        chk("late sticky", h.rfsh_late, 1);
        // reset in the middle of a read
        h.addr = 24'h000009; h.read_rq = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!h.busy && n < 50);
        h.read_rq = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrd busy", h.busy, 1);
        chk("midrd dout", h.dout, 0);
        chk("midrd late", h.rfsh_late, 0);

        // host loop, full-rate then 50% clock enable
        do_reset();
        host_loop();
        ce_rand = 1'b1;
        do_reset();
        host_loop();
        ce_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
